// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types for the writeback stage: load funct3 encodings,
//               load-queue entry layout and the default queue depth.
// Revision    : 1.0
// ============================================================================
package wb_pkg;

    localparam int unsigned LDQ_DEPTH_DEFAULT = 2;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } ld_funct3_e;

    // funct3 is kept raw so unsupported encodings survive to alignment time
    typedef struct packed {
        logic        valid;
        logic        done;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
        logic [31:0] data;
    } ldq_entry_t;

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load-data alignment and sign/zero extension.
// Revision    : 1.0
// ============================================================================
module load_align
    import wb_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_raw,
    output logic [31:0] o_data,
    output logic        o_unsupported
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0:    w_byte = i_raw[7:0];
            2'd1:    w_byte = i_raw[15:8];
            2'd2:    w_byte = i_raw[23:16];
            default: w_byte = i_raw[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_raw[31:16] : i_raw[15:0];
    end

    // Unsupported encodings fall back to a full-word load
    always_comb begin
        o_data        = i_raw;
        o_unsupported = 1'b0;
        case (i_funct3)
            LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            LD_LH:   o_data = {{16{w_half[15]}}, w_half};
            LD_LW:   o_data = i_raw;
            LD_LBU:  o_data = {24'h000000, w_byte};
            LD_LHU:  o_data = {16'h0000, w_half};
            default: o_unsupported = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Writeback stage merging ALU results with in-order load
//               responses; optional forwarding port under WB_FWD_EN.
// Revision    : 1.0
// ============================================================================
module wb_stage
    import wb_pkg::*;
#(
    parameter int unsigned LDQ_DEPTH = LDQ_DEPTH_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_alu_valid,
    input  logic [4:0]  i_alu_rd,
    input  logic [31:0] i_alu_data,
    output logic        o_alu_ready,
    input  logic        i_ld_issue,
    input  logic [4:0]  i_ld_rd,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr_lo,
    output logic        o_ld_issue_ready,
    input  logic        i_ld_resp_valid,
    input  logic [31:0] i_ld_resp_data,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data,
    output logic        o_rd_wren,
    output logic [31:0] o_busy,
    output logic        o_err
`ifdef WB_FWD_EN
    ,
    output logic        o_fwd_valid,
    output logic [4:0]  o_fwd_rd,
    output logic [31:0] o_fwd_data
`endif
);

    localparam int c_PTR_W = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(LDQ_DEPTH + 1);

    ldq_entry_t          r_ldq [LDQ_DEPTH];
    logic [c_PTR_W-1:0]  r_head;
    logic [c_PTR_W-1:0]  r_tail;
    logic [c_PTR_W-1:0]  r_rsp;
    logic [c_CNT_W-1:0]  r_count;
    logic [4:0]          r_rd_addr;
    logic [31:0]         r_rd_data;
    logic                r_rd_wren;
    logic                r_err;

    ldq_entry_t  w_head;
    ldq_entry_t  w_rsp_entry;
    logic        w_pop;
    logic        w_fill;
    logic        w_drop;
    logic        w_issue;
    logic        w_sel_valid;
    logic [4:0]  w_sel_rd;
    logic [31:0] w_sel_data;
    logic [31:0] w_aligned;
    logic        w_unsup;
    logic [31:0] w_busy;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(LDQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_head      = r_ldq[r_head];
    assign w_rsp_entry = r_ldq[r_rsp];

    // r_rsp tracks the oldest entry still waiting for memory data
    assign w_pop   = w_head.valid && w_head.done;
    assign w_fill  = i_ld_resp_valid && w_rsp_entry.valid && !w_rsp_entry.done;
    assign w_drop  = i_ld_resp_valid && !w_fill;
    assign w_issue = i_ld_issue && o_ld_issue_ready;

    assign o_ld_issue_ready = (r_count < c_CNT_W'(LDQ_DEPTH));
    assign o_alu_ready      = !w_pop;

    assign w_sel_valid = w_pop || i_alu_valid;
    assign w_sel_rd    = w_pop ? w_head.rd   : i_alu_rd;
    assign w_sel_data  = w_pop ? w_head.data : i_alu_data;

    load_align u_load_align (
        .i_funct3      (w_rsp_entry.funct3),
        .i_addr_lo     (w_rsp_entry.addr_lo),
        .i_raw         (i_ld_resp_data),
        .o_data        (w_aligned),
        .o_unsupported (w_unsup)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(LDQ_DEPTH); i++) begin
                r_ldq[i] <= '0;
            end
            r_head    <= '0;
            r_tail    <= '0;
            r_rsp     <= '0;
            r_count   <= '0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
            r_rd_wren <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // Issue, fill and pop always target distinct slots
            if (w_issue) begin
                r_ldq[r_tail] <= '{valid: 1'b1, done: 1'b0, rd: i_ld_rd,
                                   funct3: i_ld_funct3, addr_lo: i_ld_addr_lo,
                                   data: 32'h0};
                r_tail <= ptr_inc(r_tail);
            end
            if (w_fill) begin
                r_ldq[r_rsp].data <= w_aligned;
                r_ldq[r_rsp].done <= 1'b1;
                r_rsp <= ptr_inc(r_rsp);
            end
            if (w_pop) begin
                r_ldq[r_head].valid <= 1'b0;
                r_ldq[r_head].done  <= 1'b0;
                r_head <= ptr_inc(r_head);
            end
            case ({w_issue, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            r_rd_wren <= w_sel_valid && (w_sel_rd != 5'd0);
            if (w_sel_valid) begin
                r_rd_addr <= w_sel_rd;
                r_rd_data <= w_sel_data;
            end
            r_err <= r_err | w_drop | (w_fill && w_unsup);
        end
    end

    always_comb begin
        w_busy = 32'h0;
        for (int i = 0; i < int'(LDQ_DEPTH); i++) begin
            if (r_ldq[i].valid) begin
                w_busy[r_ldq[i].rd] = 1'b1;
            end
        end
`ifndef WB_FWD_EN
        // Without a forwarding path the in-flight write is still pending
        if (r_rd_wren) begin
            w_busy[r_rd_addr] = 1'b1;
        end
`endif
        w_busy[0] = 1'b0;
    end

    assign o_busy    = w_busy;
    assign o_rd_addr = r_rd_addr;
    assign o_rd_data = r_rd_data;
    assign o_rd_wren = r_rd_wren;
    assign o_err     = r_err;

`ifdef WB_FWD_EN
    assign o_fwd_valid = r_rd_wren;
    assign o_fwd_rd    = r_rd_addr;
    assign o_fwd_data  = r_rd_data;
`endif

endmodule
`default_nettype wire
